common_fifo_rd_skid_vr: RTL and testbench



---
 rtl/common_fifo_rd_skid_vr.sv | 108 ++++++++++
 tb/tb_common_fifo_rd_skid_vr.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/common_fifo_rd_skid_vr.sv
// Read-side drain stage for the shifting FIFO: pops the FIFO head into a
// 2-entry main/skid buffer and presents it on a registered valid/ready port.
//
// Handshake: an entry moves to the consumer in every cycle where
// m_valid & m_ready are both high. While m_valid=1 and m_ready=0, m_data holds
// steady. fifo_ren never depends on m_ready, so consumer back-pressure cannot
// reach the FIFO pop logic combinationally.
module common_fifo_rd_skid_vr #(
    parameter int                    DATA_WIDTH       = 1,
    parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0,
    parameter int                    CNT_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    // State encoding equals the number of buffered entries, so occupancy
    // doubles as the FSM debug view.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] main_nxt;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_nxt;
    logic                  pop;
    logic                  take;

    // Pop only from registered state and FIFO/flush inputs; a full buffer
    // (TWO) stops popping until the consumer drains one entry.
    assign fifo_ren  = ~reset & ~flush & ~fifo_empty & (state_q != ST_TWO);
    assign pop       = fifo_ren;
    assign m_valid   = (state_q != ST_EMPTY) & ~flush;
    assign take      = m_valid & m_ready;
    assign m_data    = main_q;
    assign occupancy = state_q;

    // Next-state and buffer update; flush empties the buffer but leaves data
    // registers untouched.
    always_comb begin
        state_nxt = state_q;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        main_nxt  = fifo_dout;
                    end
                end
                ST_ONE: begin
                    if (pop && take) begin
                        main_nxt = fifo_dout;
                    end else if (pop) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = fifo_dout;
                    end else if (take) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        state_nxt = ST_ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State, data and transfer-counter registers; reset wins over flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_EMPTY;
            main_q   <= DATA_RESET_VALUE;
            skid_q   <= DATA_RESET_VALUE;
            xfer_cnt <= '0;
        end else begin
            state_q <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            if (take) begin
                xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_common_fifo_rd_skid_vr.sv
// Bench for common_fifo_rd_skid_vr: a queue stands in for the upstream FIFO,
// and a queue of buffered entries predicts every output cycle by cycle.
module tb_common_fifo_rd_skid_vr;

    localparam int         DW      = 8;
    localparam int         CW      = 4;
    localparam logic [7:0] RST_VAL = 8'hA5;

    // Clock/reset block
    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          fifo_empty;
    logic          fifo_ren;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] m_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] xfer_cnt;

    always #5 clk = ~clk;

    common_fifo_rd_skid_vr #(
        .DATA_WIDTH      (DW),
        .DATA_RESET_VALUE(RST_VAL),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_ren  (fifo_ren),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .flush     (flush),
        .occupancy (occupancy),
        .xfer_cnt  (xfer_cnt)
    );

    // Upstream FIFO contents and reference model of the drain stage
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_head;
    logic [CW-1:0] exp_cnt;
    int            n_assert;
    int            n_fail;
    int            dut_pops;
    logic [DW-1:0] first_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_val(input logic [DW-1:0] v);
        fifo_q.push_back(v);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'($urandom));
    endtask

    // Driver: one clock cycle with given reset/flush/ready; checks all outputs
    // mid-cycle and advances the model at the clock edge.
    task automatic cycle(input logic rst, input logic fl, input logic rdy);
        logic          e_ren;
        logic          e_valid;
        logic          e_take;
        logic [DW-1:0] e_data;
        reset      = rst;
        flush      = fl;
        m_ready    = rdy;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? DW'($urandom) : fifo_q[0];
        #1;
        e_ren   = !rst && !fl && (fifo_q.size() != 0) && (exp_q.size() < 2);
        e_valid = (exp_q.size() != 0) && !fl;
        e_take  = e_valid && rdy;
        e_data  = (exp_q.size() != 0) ? exp_q[0] : last_head;
        check("fifo_ren",  32'(fifo_ren),  32'(e_ren));
        check("m_valid",   32'(m_valid),   32'(e_valid));
        check("m_data",    32'(m_data),    32'(e_data));
        check("occupancy", 32'(occupancy), 32'(exp_q.size()));
        check("xfer_cnt",  32'(xfer_cnt),  32'(exp_cnt));
        if (fifo_ren === 1'b1) dut_pops++;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cnt   = '0;
            last_head = RST_VAL;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (e_take) begin
                void'(exp_q.pop_front());
                exp_cnt++;
            end
            if (e_ren) exp_q.push_back(fifo_q.pop_front());
        end
        if (exp_q.size() != 0) last_head = exp_q[0];
        @(negedge clk);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        dut_pops   = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        exp_cnt    = '0;
        last_head  = RST_VAL;
        // Initial reset brings the DUT out of X before any checking
        @(negedge clk);
        @(negedge clk);

        // Reset values, including during an asserted reset cycle
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);

        // Three entries, consumer always ready
        push_val(8'h11);
        push_val(8'h22);
        push_val(8'h33);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        check("cnt_after_3", 32'(xfer_cnt), 32'd3);

        // Stall with five queued entries: exactly two pops, head held
        push_rand(5);
        first_val = fifo_q[0];
        dut_pops  = 0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0);
        check("stall_pops", 32'(dut_pops), 32'd2);
        check("stall_head", 32'(m_data), 32'(first_val));
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1);

        // Alternating ready with a well-stocked FIFO
        push_rand(12);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'(i % 2));
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1);

        // Flush while two entries are buffered
        push_rand(4);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        check("pre_flush_occ", 32'(occupancy), 32'd2);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

        // Counter wrap: 17 transfers from a cleared counter
        cycle(1'b1, 1'b0, 1'b0);
        push_rand(17);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1);
        check("cnt_wrap", 32'(xfer_cnt), 32'd1);

        // Reset mid-stream with one buffered entry
        push_rand(3);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("pre_reset_occ", 32'(occupancy), 32'd1);
        cycle(1'b1, 1'b0, 1'b1);
        check("post_reset_data", 32'(m_data), 32'(RST_VAL));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8) push_rand(1);
            cycle(1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b1);
        check("final_occ", 32'(occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
